// File: rtl/seq_divider.sv
//------------------------------------------------------------------------------
// Module   : seq_divider
// Purpose  : Sequential unsigned restoring divider. 2N-bit dividend by N-bit
//            divisor, one quotient bit per cycle, MSB first.
// Options  : SEQ_DIVIDER_OVF_CHECK_EN - when defined, zero-divisor and
//            quotient-overflow operands skip the iteration and report ovf=1.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module seq_divider #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [N-1:0]  r_rem;       // restored partial remainder (always < divisor)
  logic [N-1:0]  r_lo;        // remaining low dividend bits, consumed MSB first
  logic [N-1:0]  r_qw;        // quotient bits collected so far
  logic [N-1:0]  r_div;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_quotient;
  logic [N-1:0]  r_remainder;
  logic          r_busy;
  logic          r_done;
  logic          r_ovf;

  logic [N:0]    w_shift;
  logic          w_ge;
  logic [N-1:0]  w_diff;
  logic [N-1:0]  w_rem_next;
  logic [N-1:0]  w_qw_next;
  logic          w_last;
  logic          w_ovf_pre;

  // Iteration step: shift in next dividend bit, trial-subtract, restore on borrow.
  // When the trial succeeds the difference is below the divisor, so the low N
  // bits of a modulo-2^N subtraction are exact.
  assign w_shift    = {r_rem, r_lo[N-1]};
  assign w_ge       = (w_shift >= {1'b0, r_div});
  assign w_diff     = w_shift[N-1:0] - r_div;
  assign w_rem_next = w_ge ? w_diff : w_shift[N-1:0];
  assign w_qw_next  = (r_qw << 1) | {{(N-1){1'b0}}, w_ge};
  assign w_last     = (r_cnt == C_LAST);

`ifdef SEQ_DIVIDER_OVF_CHECK_EN
  // Quotient fits in N bits only when the upper dividend half is below divisor.
  assign w_ovf_pre = (divisor == '0) || (dividend[2*N-1:N] >= divisor);
`else
  assign w_ovf_pre = 1'b0;
`endif

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ovf       = r_ovf;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = w_ovf_pre ? DONE : CALC;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs; results hold until the next completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem       <= '0;
      r_lo        <= '0;
      r_qw        <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_div <= divisor;
            r_rem <= dividend[2*N-1:N];
            r_lo  <= dividend[N-1:0];
            r_qw  <= '0;
            r_cnt <= '0;
            if (w_ovf_pre) begin
              r_quotient  <= '1;
              r_remainder <= '0;
              r_ovf       <= 1'b1;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_busy <= 1'b1;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_lo  <= r_lo << 1;
          r_qw  <= w_qw_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_quotient  <= w_qw_next;
            r_remainder <= w_rem_next;
            r_ovf       <= 1'b0;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
//------------------------------------------------------------------------------
// Module   : tb_seq_divider
// Purpose  : Scoreboard bench for seq_divider (N=4), directed vectors.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_seq_divider;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2*N-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           ovf;

  seq_divider #(.N(N)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    q;
    int    r;
    int    ov;
    int    lat;
    bit    chk_val;
    int    acc;
    string name;
  } exp_t;

  exp_t sb[$];
  int   tests    = 0;
  int   fails    = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

`ifdef SEQ_DIVIDER_OVF_CHECK_EN
  localparam bit C_OVF_EN = 1'b1;
`else
  localparam bit C_OVF_EN = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle counter: value after edge k is k.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares each done pulse against the scoreboard head.
  initial begin
    int prev_done;
    exp_t e;
    prev_done = 0;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        done_cnt++;
        chk("done_single_cycle", prev_done, 0);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending operation", cyc);
        end else begin
          e = sb.pop_front();
          if (e.chk_val) begin
            chk({e.name, "_quotient"}, int'(quotient), e.q);
            chk({e.name, "_remainder"}, int'(remainder), e.r);
          end
          chk({e.name, "_ovf"}, int'(ovf), e.ov);
          chk({e.name, "_latency"}, cyc - e.acc + 1, e.lat);
          chk({e.name, "_busy_low"}, int'(busy), 0);
        end
      end
      prev_done = int'(done === 1'b1);
    end
  end

  // Drive one request for a single cycle and queue its expected result.
  task automatic issue(input int dvd, input int dvs, input int q, input int r,
                       input int ov, input int lat, input bit cv, input string nm);
    exp_t e;
    @(negedge clk);
    dividend = 8'(dvd);
    divisor  = 4'(dvs);
    e.q = q; e.r = r; e.ov = ov; e.lat = lat; e.chk_val = cv; e.name = nm;
    e.acc = cyc + 1;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for the scoreboard to drain, then one cycle for DONE->IDLE.
  task automatic wait_empty(input string nm);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d pending after 30 cycles, expected 0", nm, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Overflow vectors: checked result with the pre-check, timing only without it.
  task automatic issue_ovf(input int dvd, input int dvs, input string nm);
    if (C_OVF_EN) issue(dvd, dvs, 15, 0, 1, 1, 1'b1, nm);
    else          issue(dvd, dvs, 0, 0, 0, 5, 1'b0, nm);
    wait_empty(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000ns, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 100/7 with busy profile across the CALC cycles.
    issue(100, 7, 14, 2, 0, 5, 1'b1, "div_100_7");
    for (int i = 0; i < 4; i++) begin
      chk("busy_calc", int'(busy), 1);
      chk("done_calc", int'(done), 0);
      @(negedge clk);
    end
    chk("busy_at_done", int'(busy), 0);
    wait_empty("div_100_7");
    repeat (3) @(negedge clk);
    chk("hold_quotient", int'(quotient), 14);
    chk("hold_remainder", int'(remainder), 2);

    issue(225, 15, 15, 0, 0, 5, 1'b1, "div_225_15"); wait_empty("div_225_15");
    issue(15, 1, 15, 0, 0, 5, 1'b1, "div_15_1");     wait_empty("div_15_1");
    issue(0, 5, 0, 0, 0, 5, 1'b1, "div_0_5");        wait_empty("div_0_5");
    issue(200, 13, 15, 5, 0, 5, 1'b1, "div_200_13"); wait_empty("div_200_13");
    issue_ovf(255, 15, "ovf_255_15");
    issue_ovf(37, 0, "ovf_37_0");

    // Start while busy is ignored.
    d0 = done_cnt;
    issue(100, 7, 14, 2, 0, 5, 1'b1, "ign_100_7");
    @(negedge clk);
    dividend = 8'd50;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_empty("ign_100_7");
    repeat (6) @(negedge clk);
    chk("ign_done_count", done_cnt - d0, 1);
    chk("ign_quotient", int'(quotient), 14);

    // Reset on second CALC cycle aborts; start during reset is ignored.
    d0 = done_cnt;
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 4'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n    = 1'b0;
    dividend = 8'd40;
    divisor  = 4'd5;
    start    = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    chk("abort_quotient", int'(quotient), 0);
    chk("abort_remainder", int'(remainder), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_ovf", int'(ovf), 0);
    repeat (6) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle_busy", int'(busy), 0);
    issue(40, 5, 8, 0, 0, 5, 1'b1, "div_40_5");
    wait_empty("div_40_5");

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
